// File: rtl/k082_video_timing.sv
// k082_video_timing: pixel-side video timing for the Time Pilot vertical PLA.
// Generates the 9-bit horizontal/vertical counts, sync, blank and the
// vblank-entry strobe for the CPU IRQ latch.
// Optional feature macro: K082_FLIP_EN (flip inverts the low count bits).
module k082_video_timing #(
  parameter logic [8:0] H_START  = 9'd128,
  parameter logic [8:0] V_START  = 9'd248,
  parameter logic [8:0] HS_START = 9'd176,
  parameter logic [8:0] HS_END   = 9'd208,
  parameter logic [8:0] VS_START = 9'd248,
  parameter logic [8:0] VS_END   = 9'd256,
  parameter logic [8:0] VB_END   = 9'd272,
  parameter logic [8:0] VB_START = 9'd496
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cen,
  input  logic       ven,
  input  logic       flip,
  output logic [8:0] h_cnt,
  output logic       h256_n,
  output logic [8:0] v_cnt,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hblank,
  output logic       vblank,
  output logic       vbl_strobe
);

  logic [8:0] hc;
  logic [8:0] vc;
  logic [8:0] hc_nx;
  logic [8:0] vc_nx;
  logic       line_end;
  logic       v_step;

  function automatic logic in_win(input logic [8:0] x, input logic [8:0] lo,
                                  input logic [8:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic vb_dec(input logic [8:0] v);
    return (v < VB_END) || (v >= VB_START);
  endfunction

  // Next-state counters: h reloads at 511, v advances only at line end with ven.
  always_comb begin
    line_end = (hc == 9'd511);
    v_step   = line_end && ven;
    hc_nx    = line_end ? H_START : hc + 9'd1;
    vc_nx    = vc;
    if (v_step) begin
      vc_nx = (vc == 9'd511) ? V_START : vc + 9'd1;
    end
  end

  // Counters and decodes; decodes use next-state values so they line up with the counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc         <= H_START;
      vc         <= V_START;
      h256_n     <= ~H_START[8];
      hsync_n    <= ~in_win(H_START, HS_START, HS_END);
      vsync_n    <= ~in_win(V_START, VS_START, VS_END);
      hblank     <= ~H_START[8];
      vblank     <= vb_dec(V_START);
      vbl_strobe <= 1'b0;
    end else if (cen) begin
      hc         <= hc_nx;
      vc         <= vc_nx;
      h256_n     <= ~hc_nx[8];
      hsync_n    <= ~in_win(hc_nx, HS_START, HS_END);
      vsync_n    <= ~in_win(vc_nx, VS_START, VS_END);
      hblank     <= ~hc_nx[8];
      vblank     <= vb_dec(vc_nx);
      // Only a real step into VB_START fires; holding there with ven=0 does not.
      vbl_strobe <= v_step && (vc_nx == VB_START);
    end
  end

`ifdef K082_FLIP_EN
  logic flip_r;

  // Flip is captured at the line reload so inversion never changes mid-line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flip_r <= 1'b0;
    end else if (cen && line_end) begin
      flip_r <= flip;
    end
  end

  assign h_cnt = {hc[8], hc[7:0] ^ {8{flip_r}}};
  assign v_cnt = {vc[8], vc[7:0] ^ {8{flip_r}}};
`else
  logic unused_flip;

  assign unused_flip = flip;
  assign h_cnt       = hc;
  assign v_cnt       = vc;
`endif

endmodule

// File: tb/tb_k082_video_timing.sv
// Bench for k082_video_timing, run with a shortened frame so a whole frame fits.
// Each enabled step pushes the model's expected outputs; the post-edge sample pops them.
module tb_k082_video_timing;

  localparam logic [8:0] H0  = 9'd224;
  localparam logic [8:0] HS0 = 9'd240;
  localparam logic [8:0] HE0 = 9'd272;
  localparam logic [8:0] V0  = 9'd440;
  localparam logic [8:0] VS0 = 9'd440;
  localparam logic [8:0] VE0 = 9'd448;
  localparam logic [8:0] VBE = 9'd456;
  localparam logic [8:0] VBS = 9'd496;

  logic       clk;
  logic       reset;
  logic       cen;
  logic       ven;
  logic       flip;
  logic [8:0] h_cnt;
  logic       h256_n;
  logic [8:0] v_cnt;
  logic       hsync_n;
  logic       vsync_n;
  logic       hblank;
  logic       vblank;
  logic       vbl_strobe;
  logic [23:0] obs;

  int asserts = 0;
  int fails   = 0;
  int strobe_seen = 0;

  logic [8:0] mh;
  logic [8:0] mv;
  logic       mflip;
  logic       mst;
  logic [23:0] sbq[$];

  k082_video_timing #(
    .H_START(H0), .V_START(V0), .HS_START(HS0), .HS_END(HE0),
    .VS_START(VS0), .VS_END(VE0), .VB_END(VBE), .VB_START(VBS)
  ) dut (
    .clk(clk), .reset(reset), .cen(cen), .ven(ven), .flip(flip),
    .h_cnt(h_cnt), .h256_n(h256_n), .v_cnt(v_cnt), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .hblank(hblank), .vblank(vblank), .vbl_strobe(vbl_strobe)
  );

  assign obs = {h_cnt, v_cnt, h256_n, hsync_n, vsync_n, hblank, vblank, vbl_strobe};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mh = H0; mv = V0; mflip = 1'b0; mst = 1'b0;
  endtask

  task automatic model_adv(input logic vn, input logic fl);
    if (mh == 9'd511) begin
      mflip = fl;
      mh = H0;
      mst = vn && (mv == VBS - 9'd1);
      if (vn) mv = (mv == 9'd511) ? V0 : mv + 9'd1;
    end else begin
      mh = mh + 9'd1;
      mst = 1'b0;
    end
  endtask

  function automatic logic [23:0] expv();
    logic [8:0] dh;
    logic [8:0] dv;
    dh = mh;
    dv = mv;
`ifdef K082_FLIP_EN
    if (mflip) begin
      dh[7:0] = ~mh[7:0];
      dv[7:0] = ~mv[7:0];
    end
`endif
    return {dh, dv, ~mh[8], !((mh >= HS0) && (mh < HE0)), !((mv >= VS0) && (mv < VE0)),
            (mh < 9'd256), (mv < VBE) || (mv >= VBS), mst};
  endfunction

  // One clock: drive at negedge, predict, then compare just after the edge.
  task automatic step(input logic c, input logic vn, input logic fl);
    logic [23:0] e;
    @(negedge clk);
    cen = c; ven = vn; flip = fl;
    if (c) model_adv(vn, fl);
    sbq.push_back(expv());
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    asserts++;
    if (obs !== e) begin
      fails++;
      $display("FAIL step h=%0d v=%0d: got %h expected %h", mh, mv, obs, e);
    end
    if (vbl_strobe === 1'b1) strobe_seen++;
  endtask

  // Run with cen=1 until the model reaches (h,v); v<0 matches any line.
  // ven is random except at h=511, where it is 1.
  task automatic run_to(input int h, input int v, input logic fl);
    int n;
    logic vn;
    n = 0;
    while (!((mh == h) && ((v < 0) || (mv == v)))) begin
      if (n >= 40000) begin
        fails++;
        $display("FAIL run_to timeout: at h=%0d v=%0d required h=%0d v=%0d", mh, mv, h, v);
        return;
      end
      vn = (mh == 9'd511) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, vn, fl);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cen = 1'b0; ven = 1'b0; flip = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #2;
    asserts++;
    if (obs !== {H0, V0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", obs,
               {H0, V0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    cen = 1'b1; ven = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if (obs !== expv()) begin
      fails++;
      $display("FAIL reset_hold: got %h expected %h", obs, expv());
    end
    @(negedge clk);
    cen = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_line();
    int hs_low, hb, h256hi, period;
    hs_low = 0; hb = 0; h256hi = 0; period = 0;
    for (int i = 1; i <= 288; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (hsync_n === 1'b0) hs_low++;
      if (hblank === 1'b1) hb++;
      if (h256_n === 1'b1) h256hi++;
      if ((h_cnt === H0) && (period == 0)) period = i;
    end
    asserts++;
    if (period != 288) begin fails++; $display("FAIL line_period: got %0d expected 288", period); end
    asserts++;
    if (hs_low != 32) begin fails++; $display("FAIL hsync_width: got %0d expected 32", hs_low); end
    asserts++;
    if (hb != 32) begin fails++; $display("FAIL hblank_width: got %0d expected 32", hb); end
    asserts++;
    if (h256hi != 32) begin fails++; $display("FAIL h256n_high: got %0d expected 32", h256hi); end
    asserts++;
    if (v_cnt !== 9'd441) begin fails++; $display("FAIL v_advance: got %0d expected 441", v_cnt); end
  endtask

  task automatic test_frame();
    int vs_lines, vb_lines, wraps;
    logic [8:0] pv;
    vs_lines = 0; vb_lines = 0; wraps = 0;
    strobe_seen = 0;
    pv = v_cnt;
    for (int i = 0; i < 72 * 288; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (h_cnt === H0) begin
        if (vsync_n === 1'b0) vs_lines++;
        if (vblank === 1'b1) vb_lines++;
        if ((pv === 9'd511) && (v_cnt === V0)) wraps++;
        pv = v_cnt;
      end
    end
    asserts++;
    if (vs_lines != 8) begin fails++; $display("FAIL vsync_lines: got %0d expected 8", vs_lines); end
    asserts++;
    if (vb_lines != 32) begin fails++; $display("FAIL vblank_lines: got %0d expected 32", vb_lines); end
    asserts++;
    if (wraps != 1) begin fails++; $display("FAIL frame_wraps: got %0d expected 1", wraps); end
    asserts++;
    if (strobe_seen != 1) begin fails++; $display("FAIL frame_strobes: got %0d expected 1", strobe_seen); end
    asserts++;
    if (v_cnt !== 9'd441) begin fails++; $display("FAIL frame_return: got %0d expected 441", v_cnt); end
  endtask

  task automatic test_ven_hold();
    run_to(511, 460, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    asserts++;
    if (v_cnt !== 9'd460) begin fails++; $display("FAIL ven_hold: got %0d expected 460", v_cnt); end
    run_to(511, 460, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if (v_cnt !== 9'd461) begin fails++; $display("FAIL ven_resume: got %0d expected 461", v_cnt); end
    run_to(511, 495, 1'b0);
    strobe_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if (vbl_strobe !== 1'b1) begin fails++; $display("FAIL strobe_entry: got %b expected 1", vbl_strobe); end
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if (vbl_strobe !== 1'b0) begin fails++; $display("FAIL strobe_clear: got %b expected 0", vbl_strobe); end
    run_to(511, 496, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(511, 496, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_to(511, 496, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if (strobe_seen != 1) begin fails++; $display("FAIL strobe_hold_count: got %0d expected 1", strobe_seen); end
    asserts++;
    if (v_cnt !== 9'd497) begin fails++; $display("FAIL hold_release: got %0d expected 497", v_cnt); end
  endtask

  task automatic test_cen_gate();
    logic [23:0] prev;
    int adv;
    adv = 0;
    prev = obs;
    for (int i = 0; i < 400; i++) begin
      step(1'((i % 4) == 0), 1'($urandom_range(0, 1)), 1'b0);
      if ((i % 4) != 0) begin
        asserts++;
        if (obs !== prev) begin
          fails++;
          $display("FAIL cen_hold: got %h expected %h", obs, prev);
        end
      end else if (obs[23:15] !== prev[23:15]) begin
        adv++;
      end
      prev = obs;
    end
    asserts++;
    if (adv != 100) begin fails++; $display("FAIL cen_advances: got %0d expected 100", adv); end
  endtask

  task automatic test_flip();
    logic [8:0] exp_h;
    run_to(300, -1, 1'b0);
    run_to(400, -1, 1'b1);
    asserts++;
    if (h_cnt !== 9'd400) begin fails++; $display("FAIL flip_midline: got %0d expected 400", h_cnt); end
    run_to(511, -1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_to(384, -1, 1'b1);
`ifdef K082_FLIP_EN
    exp_h = 9'd383;
`else
    exp_h = 9'd384;
`endif
    asserts++;
    if (h_cnt !== exp_h) begin fails++; $display("FAIL flip_hcnt: got %0d expected %0d", h_cnt, exp_h); end
    run_to(511, -1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap_both();
    run_to(511, 511, 1'b0);
    asserts++;
    if (vsync_n !== 1'b1) begin fails++; $display("FAIL pre_wrap_vsync: got %b expected 1", vsync_n); end
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if ({h_cnt, v_cnt, vsync_n} !== {H0, V0, 1'b0}) begin
      fails++;
      $display("FAIL double_wrap: got h=%0d v=%0d vs=%b expected h=%0d v=%0d vs=0",
               h_cnt, v_cnt, vsync_n, H0, V0);
    end
  endtask

  task automatic test_async_reset();
    run_to(300, 445, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    asserts++;
    if (obs !== {H0, V0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", obs,
               {H0, V0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    cen = 1'b0;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    asserts++;
    if (h_cnt !== H0 + 9'd1) begin fails++; $display("FAIL post_reset_run: got %0d expected %0d", h_cnt, H0 + 9'd1); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_ven_hold();
    test_cen_gate();
    test_flip();
    test_wrap_both();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
